// File: rtl/proj_fm_reader_if.sv
// Command, FM buffer read port and byte stream of the FM reader.
// The master side belongs to the reader; the slave side is its environment.
interface proj_fm_reader_if #(
    parameter int unsigned FM_BUFFER_SIZE = 16,
    parameter int unsigned DATA_W         = 8
);
    localparam int unsigned ADDR_W = $clog2(FM_BUFFER_SIZE);

    logic              in_start;
    logic [ADDR_W-1:0] in_start_idx;
    logic              out_rd_en;
    logic [ADDR_W-1:0] out_rd_addr;
    logic [DATA_W-1:0] in_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              in_ready;
    logic              out_last;
    logic              out_busy;

    modport master (
        input  in_start, in_start_idx, in_rd_data, in_ready,
        output out_rd_en, out_rd_addr, out_data, out_valid, out_last, out_busy
    );

    modport slave (
        output in_start, in_start_idx, in_rd_data, in_ready,
        input  out_rd_en, out_rd_addr, out_data, out_valid, out_last, out_busy
    );
endinterface

// File: rtl/proj_fm_reader.sv
// Reads READ_ADDRESSES_COUNT consecutive bytes from the circular FM buffer and
// streams them over valid/ready through a 2-entry FIFO with a bypass path.
module proj_fm_reader #(
    parameter int unsigned FM_BUFFER_SIZE       = 16,
    parameter int unsigned READ_ADDRESSES_COUNT = 4,
    parameter int unsigned DATA_W               = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    proj_fm_reader_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(FM_BUFFER_SIZE);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              inflight_q;

    logic              valid, pop, rd_en, store, start_ok;
    logic [DATA_W-1:0] head;
    logic [2:0]        occ;

    // Returning read data is visible in the same cycle, so an empty FIFO
    // forwards in_rd_data straight to the output.
    assign valid    = (count_q != 2'd0) || inflight_q;
    assign head     = (count_q != 2'd0) ? mem_q[rd_ptr_q] : bus.in_rd_data;
    assign pop      = valid && bus.in_ready;
    assign occ      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en    = (state_q == S_RUN) && (issue_cnt_q != '0) && (occ < 3'd2);
    assign store    = inflight_q && !(pop && (count_q == 2'd0));
    assign count_d  = count_q + 2'(inflight_q) - 2'(pop);
    assign start_ok = {1'b0, bus.in_start_idx} < CNT_W'(FM_BUFFER_SIZE);

    assign bus.out_rd_en   = rd_en;
    assign bus.out_rd_addr = rd_en ? addr_q : '0;
    assign bus.out_valid   = valid;
    assign bus.out_data    = valid ? head : '0;
    assign bus.out_last    = valid && (out_cnt_q == CNT_W'(1));
    assign bus.out_busy    = (state_q == S_RUN);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    addr_d      = start_ok ? bus.in_start_idx : '0;
                    issue_cnt_d = CNT_W'(READ_ADDRESSES_COUNT);
                    out_cnt_d   = CNT_W'(READ_ADDRESSES_COUNT);
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    issue_cnt_d = issue_cnt_q - CNT_W'(1);
                    addr_d      = (addr_q == ADDR_W'(FM_BUFFER_SIZE - 1)) ? '0 : addr_q + ADDR_W'(1);
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q - CNT_W'(1);
                    if (out_cnt_q == CNT_W'(1)) state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            count_q     <= count_d;
            inflight_q  <= rd_en;
            if (store) begin
                mem_q[wr_ptr_q] <= bus.in_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop && (count_q != 2'd0)) rd_ptr_q <= ~rd_ptr_q;
        end
    end
endmodule

// File: tb/tb_proj_fm_reader.sv
// Bench for proj_fm_reader: directed vector table, hand-written corner sequences
// and a randomized phase scored against a queue-based model of the read stream.
module tb_proj_fm_reader;
    localparam int unsigned N   = 16;
    localparam int unsigned R   = 4;
    localparam int unsigned N12 = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proj_fm_reader_if #(.FM_BUFFER_SIZE(N),   .DATA_W(8)) bus   ();
    proj_fm_reader_if #(.FM_BUFFER_SIZE(N12), .DATA_W(8)) bus12 ();

    proj_fm_reader #(.FM_BUFFER_SIZE(N), .READ_ADDRESSES_COUNT(R), .DATA_W(8)) dut (
        .in_clk(clk), .in_rst(rst), .bus(bus)
    );
    proj_fm_reader #(.FM_BUFFER_SIZE(N12), .READ_ADDRESSES_COUNT(R), .DATA_W(8)) dut12 (
        .in_clk(clk), .in_rst(rst), .bus(bus12)
    );

    logic [7:0] mem [N];
    always @(posedge clk) if (bus.out_rd_en)   bus.in_rd_data   <= mem[bus.out_rd_addr];
    always @(posedge clk) if (bus12.out_rd_en) bus12.in_rd_data <= mem[bus12.out_rd_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion at %0t", nm, $time);
    endtask

    int rd_cnt = 0;
    always @(posedge clk) if (bus.out_rd_en) rd_cnt++;

    // Collects n handshakes; expected byte k is (start+k) mod wrapn with mem[i]=i.
    task automatic collect(input bit s12, input int n, input int total, input int start,
                           input int wrapn, input string nm);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            bit got = 1'b0;
            while (!got && w < 20) begin
                @(negedge clk);
                if (s12 ? (bus12.out_valid && bus12.in_ready) : (bus.out_valid && bus.in_ready)) begin
                    got = 1'b1;
                    chk({nm, "_data"}, s12 ? bus12.out_data : bus.out_data, 32'((start + k) % wrapn));
                    chk({nm, "_last"}, s12 ? bus12.out_last : bus.out_last, 32'(k == total - 1));
                end
                @(posedge clk); #1;
                w++;
            end
            if (!got) begin
                fail_timeout({nm, "_timeout"});
                return;
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd_en"}, bus.out_rd_en, 0);
        chk({nm, "_rd_addr"}, bus.out_rd_addr, 0);
        chk({nm, "_valid"}, bus.out_valid, 0);
        chk({nm, "_data"}, bus.out_data, 0);
        chk({nm, "_last"}, bus.out_last, 0);
        chk({nm, "_busy"}, bus.out_busy, 0);
    endtask

    // Reference model for the random phase: expected address and byte streams.
    logic [7:0] exp_addr [$];
    logic [7:0] exp_data [$];
    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         issued = 0;
    int         accepted = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("mon_hold_valid", bus.out_valid, 1);
                chk("mon_hold_data", bus.out_data, prev_data);
            end
            if (bus.out_rd_en) begin
                issued++;
                if (exp_addr.size() == 0) chk("mon_extra_read", 1, 0);
                else chk("mon_rd_addr", bus.out_rd_addr, exp_addr.pop_front());
            end
            if (bus.out_valid && bus.in_ready) begin
                accepted++;
                if (exp_data.size() == 0) chk("mon_extra_byte", 1, 0);
                else begin
                    chk("mon_last", bus.out_last, 32'(exp_data.size() == 1));
                    chk("mon_data", bus.out_data, exp_data.pop_front());
                end
            end
            chk("mon_occupancy", 32'(issued - accepted <= 2), 1);
            prev_stall = bus.out_valid && !bus.in_ready;
            prev_data  = bus.out_data;
        end
    end

    typedef struct {
        logic [3:0] idx;
        logic [7:0] exp [4];
        bit         poke;
    } vec_t;
    vec_t vt [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        int idx;

        vt[0].idx = 4'd3;  vt[0].exp = '{8'd3,  8'd4,  8'd5, 8'd6}; vt[0].poke = 1'b0;
        vt[1].idx = 4'd14; vt[1].exp = '{8'd14, 8'd15, 8'd0, 8'd1}; vt[1].poke = 1'b0;
        vt[2].idx = 4'd5;  vt[2].exp = '{8'd5,  8'd6,  8'd7, 8'd8}; vt[2].poke = 1'b1;
        vt[3].idx = 4'd15; vt[3].exp = '{8'd15, 8'd0,  8'd1, 8'd2}; vt[3].poke = 1'b1;

        for (int i = 0; i < int'(N); i++) mem[i] = 8'(i);
        bus.in_start = 1'b0;  bus.in_start_idx = '0;  bus.in_ready = 1'b1;
        bus12.in_start = 1'b0; bus12.in_start_idx = '0; bus12.in_ready = 1'b1;

        @(posedge clk); #1;
        chk_all_zero("reset");
        chk("reset12_valid", bus12.out_valid, 0);
        chk("reset12_busy", bus12.out_busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: cycle t after start, with optional ignored start pulses.
        for (int v = 0; v < 4; v++) begin
            bus.in_start = 1'b1;
            bus.in_start_idx = vt[v].idx;
            @(posedge clk); #1;
            for (int t = 1; t <= 7; t++) begin
                bus.in_start = vt[v].poke && (t == 2 || t == 5);
                bus.in_start_idx = 4'd9;
                @(negedge clk);
                chk("vec_rd_en", bus.out_rd_en, 32'(t <= 4));
                if (t <= 4) chk("vec_rd_addr", bus.out_rd_addr, vt[v].exp[t-1]);
                chk("vec_valid", bus.out_valid, 32'(t >= 2 && t <= 5));
                if (t >= 2 && t <= 5) chk("vec_data", bus.out_data, vt[v].exp[t-2]);
                chk("vec_last", bus.out_last, 32'(t == 5));
                chk("vec_busy", bus.out_busy, 32'(t <= 5));
                @(posedge clk); #1;
            end
            bus.in_start = 1'b0;
        end

        // Backpressure: ready low for 5 cycles after the first valid.
        bus.in_ready = 1'b0;
        base = rd_cnt;
        bus.in_start = 1'b1;
        bus.in_start_idx = 4'd0;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 0);
            @(posedge clk); #1;
        end
        chk("bp_reads", 32'(rd_cnt - base), 2);
        bus.in_ready = 1'b1;
        collect(1'b0, 4, 4, 0, N, "bp");
        @(negedge clk);
        chk("bp_busy_after", bus.out_busy, 0);
        chk("bp_valid_after", bus.out_valid, 0);
        @(posedge clk); #1;

        // Reset after two bytes, then a fresh command at index 8.
        bus.in_start = 1'b1;
        bus.in_start_idx = 4'd0;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        collect(1'b0, 2, 4, 0, N, "pre_rst");
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_valid", bus.out_valid, 0);
            chk("postrst_rd_en", bus.out_rd_en, 0);
            @(posedge clk); #1;
        end
        bus.in_start = 1'b1;
        bus.in_start_idx = 4'd8;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        collect(1'b0, 4, 4, 8, N, "restart");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("restart_no_extra", bus.out_valid, 0);
            @(posedge clk); #1;
        end

        // Out-of-range start index on the 12-entry instance.
        bus12.in_start = 1'b1;
        bus12.in_start_idx = 4'd13;
        @(posedge clk); #1;
        bus12.in_start = 1'b0;
        @(negedge clk);
        chk("oor_rd_en", bus12.out_rd_en, 1);
        chk("oor_rd_addr", bus12.out_rd_addr, 0);
        @(posedge clk); #1;
        collect(1'b1, 4, 4, 0, N12, "oor");

        // Randomized commands, ready and ignored start pulses.
        for (int i = 0; i < int'(N); i++) mem[i] = 8'($urandom);
        mon_en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            idx = int'($urandom_range(0, N - 1));
            for (int k = 0; k < int'(R); k++) begin
                exp_addr.push_back(8'((idx + k) % N));
                exp_data.push_back(mem[(idx + k) % N]);
            end
            bus.in_start = 1'b1;
            bus.in_start_idx = 4'(idx);
            bus.in_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            bus.in_start = 1'b0;
            guard = 0;
            while ((exp_data.size() != 0 || bus.out_busy) && guard < 200) begin
                bus.in_ready = ($urandom_range(0, 3) != 0);
                bus.in_start = bus.out_busy && ($urandom_range(0, 5) == 0);
                bus.in_start_idx = 4'($urandom);
                @(posedge clk); #1;
                guard++;
            end
            bus.in_start = 1'b0;
            if (guard >= 200) begin
                fail_timeout("rand_cmd");
                exp_addr.delete();
                exp_data.delete();
            end
        end
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proj_fm_reader.md
Name: proj_fm_reader

Overview:
- Read-side counterpart of the FM write index counter.
- On a start command, it reads READ_ADDRESSES_COUNT consecutive bytes from the circular FM buffer, beginning at a given index and wrapping at FM_BUFFER_SIZE.
- It drives the buffer's synchronous read port, which has 1-cycle latency.
- It streams the bytes to the downstream MinHash/extender logic over a valid/ready interface, with full throughput and backpressure.

Parameters:
- FM_BUFFER_SIZE, proj_pkg::FM_BUFFER_SIZE (bench value 16): number of byte entries in the circular FM buffer; must be >= 2.
- READ_ADDRESSES_COUNT, proj_pkg::FM_EXTENDER_BYTES_READ_COUNT (bench value 4): bytes read per command; range 1..FM_BUFFER_SIZE.
- DATA_W, 8: width of one FM entry.
- ADDR_W, $clog2(FM_BUFFER_SIZE): address width (derived; do not override).

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_start  input  1  start-command pulse; sampled only while out_busy=0.
- in_start_idx  input  ADDR_W  first buffer index to read; captured with in_start.
- out_rd_en  output  1  buffer read enable.
- out_rd_addr  output  ADDR_W  buffer read address.
- in_rd_data  input  DATA_W  buffer read data, valid the cycle after out_rd_en.
- out_data  output  DATA_W  streamed byte.
- out_valid  output  1  out_data is valid.
- in_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the final byte of the command; qualified by out_valid.
- out_busy  output  1  a command is in progress.

Behaviour:
- Reset values: all outputs are 0, the FSM is IDLE, the 2-entry output FIFO is empty, and no reads are in flight.
  - Reset is asserted asynchronously.
  - Leaving reset takes effect at the first clock edge with in_rst=0.
- FSM IDLE:
  - in_start=1 captures the address (in_start_idx, or 0 if in_start_idx >= FM_BUFFER_SIZE).
  - It also loads issue_cnt = READ_ADDRESSES_COUNT and out_cnt = READ_ADDRESSES_COUNT, then moves to RUN.
  - out_busy=1 from the next cycle.
- FSM RUN, read issue:
  - out_rd_en=1 when issue_cnt > 0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & in_ready this cycle.
  - Each issued read decrements issue_cnt.
  - The address advances by 1; FM_BUFFER_SIZE-1 wraps to 0.
  - out_rd_addr is don't-care when out_rd_en=0.
- Read return: inflight is set for the cycle after an issued read. In that cycle, in_rd_data is pushed into the FIFO. The FIFO never overflows, by construction of the issue rule.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Bytes are emitted in address order.
  - A handshake occurs when out_valid & in_ready, and decrements out_cnt.
  - out_last=1 when out_cnt==1 and out_valid=1.
  - out_data and out_valid hold stable while in_ready=0.
- Latency:
  - First out_rd_en occurs 1 cycle after in_start; first out_valid occurs 2 cycles after in_start.
  - With in_ready held high, one byte is emitted per cycle with no bubbles.
- Completion: on the handshake with out_last=1, the FSM returns to IDLE and out_busy=0 from the next cycle.
- in_start while out_busy=1 (including in the completion cycle) is ignored, and no command is queued.
- Wrap-around: a command starting at index s reads s, s+1, …, FM_BUFFER_SIZE-1, 0, 1, …, for READ_ADDRESSES_COUNT entries in total.
- Reset mid-command:
  - The command is aborted and the FIFO flushed.
  - Any read data returned in the cycle after reset is discarded.
  - No out_valid occurs until a new in_start.
- Counters are ADDR_W+1 bits wide, so READ_ADDRESSES_COUNT == FM_BUFFER_SIZE is legal and reads the whole buffer exactly once.

Test Plan:
- Basic read: start_idx=3 with in_ready=1 and buffer[i]=i -> out_rd_addr 3,4,5,6 on consecutive cycles; out_data 3,4,5,6 on 4 consecutive cycles starting 2 cycles after start; out_last on the byte 6; out_busy drops the cycle after.
- Wrap: start_idx=14 -> addresses 14,15,0,1; data 14,15,0,1; out_last on 1.
- Backpressure: start_idx=0 with in_ready low for 5 cycles after the first out_valid -> at most 2 reads are issued, out_data holds 0, then 0,1,2,3 drain in order with no loss or duplication.
- Ignored start: pulse in_start with idx=9 while busy, and again in the completion cycle -> exactly 4 bytes are emitted from the original command, and none from idx 9.
- Mid-command reset: assert in_rst after 2 bytes -> all outputs go to 0 immediately; after release, a new start at idx=8 yields exactly 8,9,10,11.
- Out-of-range index: instantiate with FM_BUFFER_SIZE=12 and start_idx=13 -> reads start at 0 (data 0,1,2,3).
